// File: rtl/noise_mixer.sv
// noise_mixer: centres a raw LFSR noise word, attenuates it by an arithmetic
// shift and adds it to a clean signed sample with saturation. The result is
// presented over a valid/ready handshake. A one-cycle o_noise_req pulse
// follows each accepted sample so the LFSR advances once per consumed word.
//
// Optional build macro NOISE_MIXER_SAT_CNT_EN enables the saturation event
// counter on o_sat_cnt. Without it, o_sat_cnt is tied to zero.
module noise_mixer #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned NOISE_WIDTH = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_sig,
  input  logic                  i_sig_valid,
  output logic                  o_sig_ready,
  input  logic [NOISE_WIDTH-1:0] i_noise,
  input  logic [1:0]            i_noise_sel,
  input  logic [3:0]            i_shift,
  output logic                  o_noise_req,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [15:0]           o_sat_cnt
);

  // Noise and sum arithmetic are carried one bit wider than the sample so the
  // signed sum never wraps before the clamp decision.
  localparam int unsigned SumWidth = DATA_WIDTH + 1;

  localparam logic [NOISE_WIDTH-1:0] MaskFull = '1;
  localparam logic [NOISE_WIDTH-1:0] Mask12   = NOISE_WIDTH'(12'hfff);
  localparam logic [NOISE_WIDTH-1:0] Mask16   = NOISE_WIDTH'(16'hffff);
  localparam logic [NOISE_WIDTH-1:0] Mask18   = NOISE_WIDTH'(18'h3ffff);

  localparam logic [SumWidth-1:0] One      = SumWidth'(1);
  localparam logic [SumWidth-1:0] HalfFull = One << (NOISE_WIDTH - 1);
  localparam logic [SumWidth-1:0] Half12   = One << 11;
  localparam logic [SumWidth-1:0] Half16   = One << 15;
  localparam logic [SumWidth-1:0] Half18   = One << 17;

  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Narrow noise modes need at least 18 bits of raw noise, and the centred
  // noise must fit the widened sum.
  if (NOISE_WIDTH < 18 || NOISE_WIDTH > DATA_WIDTH) begin : gen_bad_width
    $error("noise_mixer: NOISE_WIDTH must be within 18..DATA_WIDTH");
  end

  // Handshake
  logic adv;
  logic accept;

  // Stage 1
  logic                       s1_valid;
  logic [DATA_WIDTH-1:0]      s1_sig;
  logic signed [SumWidth-1:0] s1_noise;

  // Stage 2 (output register)
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_sample;
  logic                  noise_req;

  // Noise conditioning
  logic [NOISE_WIDTH-1:0]     noise_mask;
  logic signed [SumWidth-1:0] noise_half;
  logic signed [SumWidth-1:0] noise_ext;
  logic signed [SumWidth-1:0] noise_c;
  logic signed [SumWidth-1:0] noise_s;

  // Saturating add
  logic signed [SumWidth-1:0] sum;
  logic                       pos_sat;
  logic                       neg_sat;
  logic                       sat_flag;
  logic [DATA_WIDTH-1:0]      sum_clamped;

  // Both stages move together whenever the output slot is free or drained.
  assign adv         = ~out_valid | i_ready;
  assign accept      = i_sig_valid & adv;
  assign o_sig_ready = adv;

  // Select the active noise width and centre the word to zero mean, then attenuate.
  always_comb begin
    noise_mask = MaskFull;
    noise_half = HalfFull;
    unique case (i_noise_sel)
      2'd0: begin
        noise_mask = MaskFull;
        noise_half = HalfFull;
      end
      2'd1: begin
        noise_mask = Mask12;
        noise_half = Half12;
      end
      2'd2: begin
        noise_mask = Mask16;
        noise_half = Half16;
      end
      2'd3: begin
        noise_mask = Mask18;
        noise_half = Half18;
      end
      default: begin
        noise_mask = MaskFull;
        noise_half = HalfFull;
      end
    endcase
    noise_ext = signed'({{(SumWidth-NOISE_WIDTH){1'b0}}, i_noise & noise_mask});
    noise_c   = noise_ext - noise_half;
    noise_s   = noise_c >>> i_shift;
  end

  // Add the attenuated noise to the signal and clamp to the sample range.
  always_comb begin
    sum         = signed'({s1_sig[DATA_WIDTH-1], s1_sig}) + s1_noise;
    // Top two bits disagree only when the sum left the DATA_WIDTH range.
    pos_sat     = ~sum[SumWidth-1] & sum[SumWidth-2];
    neg_sat     = sum[SumWidth-1] & ~sum[SumWidth-2];
    sum_clamped = sum[DATA_WIDTH-1:0];
    if (pos_sat) begin
      sum_clamped = MaxPos;
    end else if (neg_sat) begin
      sum_clamped = MinNeg;
    end
    sat_flag = (pos_sat | neg_sat) & s1_valid;
  end

  // Stage 1: register signal and conditioned noise; inputs are only taken on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sig   <= '0;
      s1_noise <= '0;
    end else if (adv) begin
      s1_valid <= i_sig_valid;
      if (accept) begin
        s1_sig   <= i_sig;
        s1_noise <= noise_s;
      end
    end
  end

  // Stage 2: output register; a bubble leaves the previous sample value in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sample <= sum_clamped;
      end
    end
  end

  // LFSR advance request: one cycle after each accept, so each word is used once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      noise_req <= 1'b0;
    end else begin
      noise_req <= accept;
    end
  end

  assign o_valid     = out_valid;
  assign o_sample    = out_sample;
  assign o_noise_req = noise_req;

`ifdef NOISE_MIXER_SAT_CNT_EN
  logic [15:0] sat_cnt;

  // Count clamped samples as they enter the output register; stick at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sat_cnt <= '0;
    end else if (adv && sat_flag && (sat_cnt != 16'hffff)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign o_sat_cnt = sat_cnt;
`else
  logic unused_sat_flag;
  assign unused_sat_flag = sat_flag;
  assign o_sat_cnt       = 16'd0;
`endif

endmodule

// File: tb/tb_noise_mixer.sv
// Self-checking bench for noise_mixer: a behavioural model fills a scoreboard
// queue at each accept; entries are popped when the DUT hands a sample over.
module tb_noise_mixer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [23:0] i_sig = '0;
  logic        i_sig_valid = 1'b0;
  logic        o_sig_ready;
  logic [23:0] i_noise = '0;
  logic [1:0]  i_noise_sel = '0;
  logic [3:0]  i_shift = '0;
  logic        o_noise_req;
  logic [23:0] o_sample;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_sat_cnt;

  int checks = 0;
  int errors = 0;
  longint exp_q[$];
  int acc_cnt = 0;
  int req_cnt = 0;
  int exp_sat = 0;
  bit prev_acc = 1'b0;

  noise_mixer #(
    .DATA_WIDTH (24),
    .NOISE_WIDTH(24)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sig      (i_sig),
    .i_sig_valid(i_sig_valid),
    .o_sig_ready(o_sig_ready),
    .i_noise    (i_noise),
    .i_noise_sel(i_noise_sel),
    .i_shift    (i_shift),
    .o_noise_req(o_noise_req),
    .o_sample   (o_sample),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sat_cnt  (o_sat_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input logic [23:0] s, input logic [23:0] n,
                                   input logic [1:0] sel, input logic [3:0] sh,
                                   output bit sat);
    longint sv;
    longint nm;
    longint c;
    longint sum;
    int w;
    sv = longint'($signed(s));
    case (sel)
      2'd0: w = 24;
      2'd1: w = 12;
      2'd2: w = 16;
      default: w = 18;
    endcase
    nm  = longint'(n) & ((longint'(1) << w) - 1);
    c   = nm - (longint'(1) << (w - 1));
    sum = sv + (c >>> sh);
    sat = 1'b0;
    if (sum > 8388607) begin
      sum = 8388607;
      sat = 1'b1;
    end else if (sum < -8388608) begin
      sum = -8388608;
      sat = 1'b1;
    end
    return sum;
  endfunction

  // Scoreboard and LFSR-request monitor, sampled away from the active edge.
  always @(negedge i_clk) begin : monitor
    bit s;
    longint e;
    if (i_rst) begin
      exp_q.delete();
      prev_acc = 1'b0;
      exp_sat  = 0;
    end else begin
      check_val("noise_req", o_noise_req, prev_acc);
      if (o_noise_req) req_cnt++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check_val("spurious_valid", o_valid, 0);
        else check_val("sample", $signed(o_sample), exp_q.pop_front());
      end
      prev_acc = i_sig_valid && o_sig_ready;
      if (prev_acc) begin
        acc_cnt++;
        e = model(i_sig, i_noise, i_noise_sel, i_shift, s);
        exp_q.push_back(e);
        if (s) exp_sat++;
      end
    end
  end

  task automatic send(input logic [23:0] s, input logic [23:0] n, input logic [1:0] sel,
                      input logic [3:0] sh);
    int waited = 0;
    i_sig = s;
    i_noise = n;
    i_noise_sel = sel;
    i_shift = sh;
    i_sig_valid = 1'b1;
    @(negedge i_clk);
    while (!o_sig_ready && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_sig_ready) check_val("send_wait", o_sig_ready, 1);
    @(posedge i_clk);
    #1;
    i_sig_valid = 1'b0;
  endtask

  task automatic drain();
    i_sig_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0 && !o_valid) break;
      @(posedge i_clk);
      #1;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic check_sat();
`ifdef NOISE_MIXER_SAT_CNT_EN
    check_val("sat_cnt", o_sat_cnt, exp_sat);
`else
    check_val("sat_cnt", o_sat_cnt, 0);
`endif
  endtask

  initial begin : stim
    logic [23:0] held;
    bit r;
    int idx;
    int a0;

    // Reset state
    #1;
    check_val("rst_valid", o_valid, 0);
    check_val("rst_sample", o_sample, 0);
    check_val("rst_req", o_noise_req, 0);
    check_val("rst_sat", o_sat_cnt, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check_val("ready_after_rst", o_sig_ready, 1);

    // Centre check with explicit two-cycle latency
    send(24'h000000, 24'h800000, 2'd0, 4'd0);
    check_val("latency_s1", o_valid, 0);
    @(posedge i_clk);
    #1;
    check_val("latency_s2", o_valid, 1);
    check_val("centre", $signed(o_sample), 0);
    drain();

    // Saturation, shift and narrow modes
    send(24'd8388600, 24'hffffff, 2'd0, 4'd0);
    drain();
    check_sat();
    send(-24'sd8388600, 24'h000000, 2'd0, 4'd0);
    send(24'd100, 24'hffffff, 2'd0, 4'd4);
    send(24'd10, 24'h000fff, 2'd1, 4'd0);
    send(24'd10, 24'h000000, 2'd1, 4'd0);
    drain();
    check_sat();

    // Backpressure: only two samples fit while the consumer stalls
    i_ready = 1'b0;
    i_sig_valid = 1'b1;
    idx = 0;
    a0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      i_sig = 24'(1000 * (idx + 1));
      i_noise = 24'(idx * 24'h1234 + 24'h5000);
      i_noise_sel = 2'd2;
      i_shift = 4'(idx);
      @(negedge i_clk);
      r = o_sig_ready;
      @(posedge i_clk);
      #1;
      if (r) idx++;
    end
    check_val("bp_accepts", acc_cnt - a0, 2);
    check_val("bp_ready", o_sig_ready, 0);
    check_val("bp_valid", o_valid, 1);
    held = o_sample;
    repeat (2) @(posedge i_clk);
    #1;
    check_val("bp_stable", o_sample, held);
    i_ready = 1'b1;
    send(24'(1000 * (idx + 1)), 24'(idx * 24'h1234 + 24'h5000), 2'd2, 4'(idx));
    drain();

    // Random stream with random bubbles, stalls and mode changes
    for (int c = 0; c < 300; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_sig_valid = ($urandom_range(0, 3) != 0);
      i_sig = 24'($urandom);
      i_noise = 24'($urandom);
      i_noise_sel = 2'($urandom_range(0, 3));
      i_shift = 4'($urandom_range(0, 15));
      @(posedge i_clk);
      #1;
    end
    drain();
    check_sat();
    check_val("req_vs_accept", req_cnt, acc_cnt);

    // Reset with both stages full
    i_ready = 1'b0;
    send(24'd77, 24'h123456, 2'd0, 4'd1);
    send(24'd88, 24'h654321, 2'd0, 4'd2);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    check_val("midrst_valid", o_valid, 0);
    check_val("midrst_sample", o_sample, 0);
    check_val("midrst_req", o_noise_req, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_val("post_rst_valid", o_valid, 0);
    send(24'd5, 24'h800003, 2'd0, 4'd0);
    drain();
    check_sat();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule
